// File: rtl/noc_input_buffer_if.sv
// Bundle of link-side and fcu-side signals for one NoC router input buffer.
// The master modport is the buffer's view; the slave modport is the
// surrounding router/link environment that feeds and drains it.

interface noc_input_buffer_if #(
   parameter int DATA_W = 32,
   parameter int PTR_W  = 2
) ();

   // upstream link side
   logic                in_valid;
   logic [DATA_W+1:0]   in_flit;
   logic                credit_out;

   // downstream fcu side
   logic                out_valid;
   logic [DATA_W+1:0]   out_flit;
   logic                out_sop;
   logic                out_eop;
   logic                out_ready;
   logic                pkt_active;

   // status
   logic [PTR_W:0]      count;
   logic                overflow_err;
   logic                proto_err;

   modport master (
      input  in_valid,
      input  in_flit,
      input  out_ready,
      output credit_out,
      output out_valid,
      output out_flit,
      output out_sop,
      output out_eop,
      output pkt_active,
      output count,
      output overflow_err,
      output proto_err
   );

   modport slave (
      output in_valid,
      output in_flit,
      output out_ready,
      input  credit_out,
      input  out_valid,
      input  out_flit,
      input  out_sop,
      input  out_eop,
      input  pkt_active,
      input  count,
      input  overflow_err,
      input  proto_err
   );

endinterface

// File: rtl/noc_input_buffer.sv
// Per-port input buffer of the NoC router. Stores incoming flits in a
// credit-managed circular FIFO, presents the head flit to the flow control
// unit, returns one credit upstream per consumed flit and watches the packet
// framing of the incoming link for diagnostic purposes.

module noc_input_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2
) (
   input  logic                clk,
   input  logic                rst,
   noc_input_buffer_if.master  bus
);

   localparam int FLIT_W = DATA_W + 2;

   localparam logic [1:0] TYPE_BODY   = 2'b00;
   localparam logic [1:0] TYPE_HEAD   = 2'b01;
   localparam logic [1:0] TYPE_TAIL   = 2'b10;
   localparam logic [1:0] TYPE_SINGLE = 2'b11;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_IN_PKT = 1'b1;

   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count_q;
   logic              credit_q;
   logic              pkt_active_q;
   logic              overflow_q;
   logic              proto_q;
   logic [0:0]        in_state;

   logic              full;
   logic              empty;
   logic              do_deq;
   logic              do_enq;
   logic              do_drop;
   logic [1:0]        in_type;
   logic [1:0]        head_type;
   logic [FLIT_W-1:0] head_flit;
   logic              frame_bad;
   logic [0:0]        in_state_nxt;

   // Occupancy flags and the transfer decisions for this cycle. A full buffer
   // can still accept a flit when the head leaves in the same cycle.
   always_comb begin
      full      = (count_q == FULL_COUNT);
      empty     = (count_q == '0);
      do_deq    = !empty && bus.out_ready;
      do_enq    = bus.in_valid && (!full || do_deq);
      do_drop   = bus.in_valid && full && !do_deq;
      in_type   = bus.in_flit[FLIT_W-1:DATA_W];
      head_flit = mem[rd_ptr];
      head_type = head_flit[FLIT_W-1:DATA_W];
   end

   // Input framing check: decides the next framing state and whether the
   // arriving flit breaks the head/body/tail sequence.
   always_comb begin
      in_state_nxt = in_state;
      frame_bad    = 1'b0;
      if (bus.in_valid) begin
         if (in_state == ST_IDLE) begin
            case (in_type)
               TYPE_HEAD:   in_state_nxt = ST_IN_PKT;
               TYPE_SINGLE: in_state_nxt = ST_IDLE;
               default:     frame_bad    = 1'b1;
            endcase
         end else begin
            case (in_type)
               TYPE_BODY:   in_state_nxt = ST_IN_PKT;
               TYPE_TAIL:   in_state_nxt = ST_IDLE;
               default:     frame_bad    = 1'b1;
            endcase
         end
      end
   end

   // Flit storage; contents need no reset because out_valid masks stale data.
   always_ff @(posedge clk) begin
      if (do_enq) begin
         mem[wr_ptr] <= bus.in_flit;
      end
   end

   // Pointers and occupancy; a reset discards everything buffered.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_enq) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_deq) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_enq && !do_deq) begin
            count_q <= count_q + 1'b1;
         end else if (do_deq && !do_enq) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   // One credit goes back upstream in the cycle after each dequeue.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_q <= 1'b0;
      end else begin
         credit_q <= do_deq;
      end
   end

   // Output-side packet tracking so the fcu can hold its allocation.
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_active_q <= 1'b0;
      end else if (do_deq) begin
         if (head_type == TYPE_HEAD) begin
            pkt_active_q <= 1'b1;
         end else if (head_type == TYPE_TAIL) begin
            pkt_active_q <= 1'b0;
         end
      end
   end

   // Framing state plus the sticky diagnostic error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_state   <= ST_IDLE;
         overflow_q <= 1'b0;
         proto_q    <= 1'b0;
      end else begin
         in_state <= in_state_nxt;
         if (do_drop) begin
            overflow_q <= 1'b1;
         end
         if (frame_bad) begin
            proto_q <= 1'b1;
         end
      end
   end

   assign bus.out_valid    = !empty;
   assign bus.out_flit     = head_flit;
   assign bus.out_sop      = !empty && ((head_type == TYPE_HEAD) || (head_type == TYPE_SINGLE));
   assign bus.out_eop      = !empty && ((head_type == TYPE_TAIL) || (head_type == TYPE_SINGLE));
   assign bus.credit_out   = credit_q;
   assign bus.pkt_active   = pkt_active_q;
   assign bus.count        = count_q;
   assign bus.overflow_err = overflow_q;
   assign bus.proto_err    = proto_q;

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed testbench for noc_input_buffer with DATA_W=32, DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_noc_input_buffer;

   localparam int DATA_W = 32;
   localparam int PTR_W  = 2;

   localparam logic [1:0] T_BODY   = 2'b00;
   localparam logic [1:0] T_HEAD   = 2'b01;
   localparam logic [1:0] T_TAIL   = 2'b10;
   localparam logic [1:0] T_SINGLE = 2'b11;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   noc_input_buffer_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) bus ();

   noc_input_buffer #(.DATA_W(DATA_W), .DEPTH(4), .PTR_W(PTR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DATA_W+1:0] mk(input logic [1:0] t, input logic [DATA_W-1:0] p);
      return {t, p};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_flit   = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++;
      if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", bus.count); end
      checks++;
      if (bus.credit_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_credit got=%b exp=0", bus.credit_out); end
      checks++;
      if (bus.overflow_err !== 1'b0 || bus.proto_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_errors got=%b%b exp=00", bus.overflow_err, bus.proto_err); end
      checks++;
      if (bus.pkt_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_pkt_active got=%b exp=0", bus.pkt_active); end
      checks++;
      // out_ready while empty must be ignored
      bus.out_ready = 1'b1;
      step();
      step();
      if (bus.count !== 3'd0 || bus.credit_out !== 1'b0) begin errors++; $display("[TB] FAIL empty_ready got count=%0d credit=%b exp count=0 credit=0", bus.count, bus.credit_out); end
      checks++;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_single_packet();
      logic [DATA_W+1:0] f [3];
      f[0] = mk(T_HEAD, 32'hA1);
      f[1] = mk(T_BODY, 32'hA2);
      f[2] = mk(T_TAIL, 32'hA3);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_flit  = f[i];
         step();
         if (bus.out_valid !== 1'b1 || bus.out_flit !== f[i]) begin errors++; $display("[TB] FAIL pkt_flit%0d got v=%b %h exp v=1 %h", i, bus.out_valid, bus.out_flit, f[i]); end
         checks++;
         if (bus.out_sop !== (i == 0) || bus.out_eop !== (i == 2)) begin errors++; $display("[TB] FAIL pkt_sop_eop%0d got %b%b exp %b%b", i, bus.out_sop, bus.out_eop, i == 0, i == 2); end
         checks++;
         if (bus.pkt_active !== (i != 0) || bus.credit_out !== (i != 0)) begin errors++; $display("[TB] FAIL pkt_active_credit%0d got %b%b exp %b%b", i, bus.pkt_active, bus.credit_out, i != 0, i != 0); end
         checks++;
      end
      bus.in_valid = 1'b0;
      step();
      if (bus.out_valid !== 1'b0 || bus.pkt_active !== 1'b0 || bus.credit_out !== 1'b1 || bus.count !== 3'd0) begin
         errors++; $display("[TB] FAIL pkt_end got v=%b act=%b cr=%b cnt=%0d exp 0 0 1 0", bus.out_valid, bus.pkt_active, bus.credit_out, bus.count);
      end
      checks++;
      step();
      if (bus.credit_out !== 1'b0 || bus.proto_err !== 1'b0) begin errors++; $display("[TB] FAIL pkt_idle got cr=%b proto=%b exp 0 0", bus.credit_out, bus.proto_err); end
      checks++;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_fill_overflow();
      int exp_cnt;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_flit  = mk(T_SINGLE, 32'h10 + i);
         step();
         exp_cnt = (i < 4) ? i + 1 : 4;
         if (int'(bus.count) !== exp_cnt || bus.overflow_err !== (i == 4)) begin
            errors++; $display("[TB] FAIL fill%0d got cnt=%0d ovf=%b exp cnt=%0d ovf=%b", i, bus.count, bus.overflow_err, exp_cnt, i == 4);
         end
         checks++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (bus.out_valid !== 1'b1 || bus.out_flit !== mk(T_SINGLE, 32'h10 + i)) begin
            errors++; $display("[TB] FAIL drain_flit%0d got v=%b %h exp v=1 %h", i, bus.out_valid, bus.out_flit, mk(T_SINGLE, 32'h10 + i));
         end
         checks++;
         step();
         if (bus.credit_out !== 1'b1 || int'(bus.count) !== 3 - i) begin
            errors++; $display("[TB] FAIL drain_credit%0d got cr=%b cnt=%0d exp cr=1 cnt=%0d", i, bus.credit_out, bus.count, 3 - i);
         end
         checks++;
      end
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_dropped got v=%b exp 0", bus.out_valid); end
      checks++;
      step();
      if (bus.credit_out !== 1'b0 || bus.overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL drain_end got cr=%b ovf=%b exp cr=0 ovf=1", bus.credit_out, bus.overflow_err); end
      checks++;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_full_simultaneous();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_flit  = mk(T_SINGLE, 32'h20 + i);
         step();
      end
      if (bus.count !== 3'd4) begin errors++; $display("[TB] FAIL full_count got=%0d exp=4", bus.count); end
      checks++;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.in_flit = mk(T_SINGLE, 32'h24 + k);
         if (bus.out_flit !== mk(T_SINGLE, 32'h20 + k)) begin
            errors++; $display("[TB] FAIL full_order%0d got %h exp %h", k, bus.out_flit, mk(T_SINGLE, 32'h20 + k));
         end
         checks++;
         step();
         if (bus.count !== 3'd4 || bus.credit_out !== 1'b1) begin
            errors++; $display("[TB] FAIL full_cycle%0d got cnt=%0d cr=%b exp cnt=4 cr=1", k, bus.count, bus.credit_out);
         end
         checks++;
      end
      bus.in_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         if (bus.out_flit !== mk(T_SINGLE, 32'h28 + j)) begin
            errors++; $display("[TB] FAIL full_tail%0d got %h exp %h", j, bus.out_flit, mk(T_SINGLE, 32'h28 + j));
         end
         checks++;
         step();
      end
      if (bus.out_valid !== 1'b0 || bus.overflow_err !== 1'b0 || bus.proto_err !== 1'b0) begin
         errors++; $display("[TB] FAIL full_end got v=%b ovf=%b proto=%b exp 0 0 0", bus.out_valid, bus.overflow_err, bus.proto_err);
      end
      checks++;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_protocol();
      apply_reset();
      bus.in_valid = 1'b1;
      bus.in_flit  = mk(T_BODY, 32'h55);
      step();
      if (bus.proto_err !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_flit !== mk(T_BODY, 32'h55)) begin
         errors++; $display("[TB] FAIL proto_body got err=%b v=%b %h exp err=1 v=1 %h", bus.proto_err, bus.out_valid, bus.out_flit, mk(T_BODY, 32'h55));
      end
      checks++;
      bus.in_flit = mk(T_HEAD, 32'h56);
      step();
      if (bus.proto_err !== 1'b1 || dut.in_state !== 1'b1) begin errors++; $display("[TB] FAIL proto_head1 got err=%b st=%b exp 1 1", bus.proto_err, dut.in_state); end
      checks++;
      bus.in_flit = mk(T_HEAD, 32'h57);
      step();
      if (bus.proto_err !== 1'b1 || dut.in_state !== 1'b1 || bus.count !== 3'd3) begin
         errors++; $display("[TB] FAIL proto_head2 got err=%b st=%b cnt=%0d exp 1 1 3", bus.proto_err, dut.in_state, bus.count);
      end
      checks++;
      bus.in_flit = mk(T_TAIL, 32'h58);
      step();
      if (dut.in_state !== 1'b0) begin errors++; $display("[TB] FAIL proto_tail got st=%b exp 0", dut.in_state); end
      checks++;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_packet();
      apply_reset();
      bus.in_valid = 1'b1;
      bus.in_flit  = mk(T_HEAD, 32'hB0);
      step();
      for (int i = 1; i < 4; i++) begin
         bus.in_flit = mk(T_BODY, 32'hB0 + i);
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      step();
      if (bus.count !== 3'd3 || bus.pkt_active !== 1'b1 || bus.credit_out !== 1'b0) begin
         errors++; $display("[TB] FAIL midrst_setup got cnt=%0d act=%b cr=%b exp 3 1 0", bus.count, bus.pkt_active, bus.credit_out);
      end
      checks++;
      rst = 1'b1;
      bus.out_ready = 1'b1;
      step();
      rst = 1'b0;
      bus.out_ready = 1'b0;
      if (bus.count !== 3'd0 || bus.pkt_active !== 1'b0 || bus.out_valid !== 1'b0 || bus.credit_out !== 1'b0) begin
         errors++; $display("[TB] FAIL midrst_clear got cnt=%0d act=%b v=%b cr=%b exp 0 0 0 0", bus.count, bus.pkt_active, bus.out_valid, bus.credit_out);
      end
      checks++;
      bus.in_valid = 1'b1;
      bus.in_flit  = mk(T_HEAD, 32'hC1);
      step();
      if (bus.credit_out !== 1'b0 || bus.out_flit !== mk(T_HEAD, 32'hC1) || bus.out_sop !== 1'b1) begin
         errors++; $display("[TB] FAIL midrst_head got cr=%b %h sop=%b exp cr=0 %h sop=1", bus.credit_out, bus.out_flit, bus.out_sop, mk(T_HEAD, 32'hC1));
      end
      checks++;
      bus.out_ready = 1'b1;
      bus.in_flit   = mk(T_TAIL, 32'hC2);
      step();
      if (bus.pkt_active !== 1'b1 || bus.credit_out !== 1'b1 || bus.out_flit !== mk(T_TAIL, 32'hC2) || bus.out_eop !== 1'b1) begin
         errors++; $display("[TB] FAIL midrst_tail got act=%b cr=%b %h eop=%b exp 1 1 %h 1", bus.pkt_active, bus.credit_out, bus.out_flit, bus.out_eop, mk(T_TAIL, 32'hC2));
      end
      checks++;
      bus.in_valid = 1'b0;
      step();
      if (bus.pkt_active !== 1'b0 || bus.count !== 3'd0 || bus.proto_err !== 1'b0) begin
         errors++; $display("[TB] FAIL midrst_done got act=%b cnt=%0d proto=%b exp 0 0 0", bus.pkt_active, bus.count, bus.proto_err);
      end
      checks++;
      bus.out_ready = 1'b0;
   endtask

   // run the scenarios in order
   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_flit   = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_packet();
      test_fill_overflow();
      test_full_simultaneous();
      test_protocol();
      test_reset_mid_packet();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // guard against a stuck run
   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
